// File: rtl/load_cache_port_if.sv
// load_cache_port_if: loader read, store update and memory fill signals of the load cache port
interface load_cache_port_if #(parameter int WORD_SIZE = 32);
  logic                 c_read_enable;
  logic [WORD_SIZE-1:0] c_ptr;
  logic [WORD_SIZE-1:0] c_out;
  logic                 c_hit;
  logic                 c_ready;
  logic                 st_enable;
  logic [WORD_SIZE-1:0] st_addr;
  logic [WORD_SIZE-1:0] st_data;
  logic                 mem_req;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;
  modport master (
    output c_read_enable, c_ptr, st_enable, st_addr, st_data, mem_rdata, mem_ack,
    input  c_out, c_hit, c_ready, mem_req, mem_addr
  );
  modport slave (
    input  c_read_enable, c_ptr, st_enable, st_addr, st_data, mem_rdata, mem_ack,
    output c_out, c_hit, c_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/load_cache_port.sv
// load_cache_port: direct-mapped write-through read cache for the loader; CACHE_STATS_EN adds hit/miss counters
module load_cache_port #(
  parameter int WORD_SIZE  = 32,
  parameter int INDEX_BITS = 4
) (
  input logic clk,
  input logic reset,
  load_cache_port_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
`endif
);
  localparam int LINES = 2 ** INDEX_BITS;
  typedef enum logic [1:0] {IDLE, MISS, DONE} state_t;
  state_t state, state_n;
  logic [LINES-1:0]                valid;
  logic [WORD_SIZE-1:INDEX_BITS]   tags [LINES];
  logic [WORD_SIZE-1:0]            data [LINES];
  logic [WORD_SIZE-1:0]            fwd_data, fill;
  logic                            fwd, hit, accept, st_hit, st_pend, ack;
  logic [INDEX_BITS-1:0]           r_idx, s_idx, f_idx;
  // lookup, store match, fill data selection and next state; mem_addr doubles as the pending miss address
  always_comb begin
    r_idx   = bus.c_ptr[INDEX_BITS-1:0];
    s_idx   = bus.st_addr[INDEX_BITS-1:0];
    f_idx   = bus.mem_addr[INDEX_BITS-1:0];
    hit     = valid[r_idx] && tags[r_idx] == bus.c_ptr[WORD_SIZE-1:INDEX_BITS];
    accept  = state == IDLE && bus.c_read_enable;
    st_hit  = bus.st_enable && valid[s_idx] && tags[s_idx] == bus.st_addr[WORD_SIZE-1:INDEX_BITS];
    st_pend = bus.st_enable && state == MISS && bus.st_addr == bus.mem_addr;
    ack     = state == MISS && bus.mem_ack;
    fill    = st_pend ? bus.st_data : fwd ? fwd_data : bus.mem_rdata;
    state_n = state == IDLE ? (bus.c_read_enable ? (hit ? DONE : MISS) : IDLE) :
              state == MISS ? (bus.mem_ack ? DONE : MISS) : IDLE;
  end
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // line updates, store forwarding and response registers; the fill is written last so it wins its index
  always_ff @(posedge clk)
    if (reset) begin
      valid        <= '0;
      fwd          <= 1'b0;
      bus.c_out    <= '0;
      bus.c_hit    <= 1'b0;
      bus.c_ready  <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      bus.c_ready <= 1'b0;
      if (st_hit)
        data[s_idx] <= bus.st_data;
      if (st_pend) begin
        fwd      <= 1'b1;
        fwd_data <= bus.st_data;
      end
      if (accept && hit) begin
        bus.c_out   <= (bus.st_enable && bus.st_addr == bus.c_ptr) ? bus.st_data : data[r_idx];
        bus.c_hit   <= 1'b1;
        bus.c_ready <= 1'b1;
      end
      if (accept && !hit) begin
        fwd          <= 1'b0;
        bus.mem_req  <= 1'b1;
        bus.mem_addr <= bus.c_ptr;
      end
      if (ack) begin
        valid[f_idx] <= 1'b1;
        tags[f_idx]  <= bus.mem_addr[WORD_SIZE-1:INDEX_BITS];
        data[f_idx]  <= fill;
        bus.c_out    <= fill;
        bus.c_hit    <= 1'b0;
        bus.c_ready  <= 1'b1;
        bus.mem_req  <= 1'b0;
      end
    end
`ifdef CACHE_STATS_EN
  // saturating hit and fill counters
  always_ff @(posedge clk)
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept && hit && !(&hit_count))
        hit_count <= hit_count + 1'b1;
      if (ack && !(&miss_count))
        miss_count <= miss_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_load_cache_port.sv
// tb_load_cache_port: randomized scoreboard bench for load_cache_port against a line-level cache model
module tb_load_cache_port;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ack_dly = 3;
  bit   started = 1'b0;
  load_cache_port_if #(.WORD_SIZE(32)) bus ();
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  logic [31:0] mh, mm;
  load_cache_port #(.WORD_SIZE(32), .INDEX_BITS(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .hit_count(hit_count), .miss_count(miss_count));
`else
  load_cache_port #(.WORD_SIZE(32), .INDEX_BITS(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
`endif
  always #5 clk = ~clk;
  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        h;
  } rsp_t;
  rsp_t q[$];
  bit          cv [16];
  logic [31:0] ca [16];
  logic [31:0] cd [16];
  int          busy;
  int          b0;
  logic [31:0] m_addr, m_fd, fv;
  bit          m_fwd, exp_req, exp_rst;
  logic [31:0] exp_maddr;
  rsp_t        pr, r;
  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h25:  return 32'hDEADBEEF;
      32'h35:  return 32'h11111111;
      32'h07:  return 32'h00000000;
      default: return a * 32'h9E3779B1 + 32'h1;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // reference model: each line remembers the full word address it holds
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      started = 1'b1;
      exp_rst = 1'b1;
      busy = 0;
      exp_req = 1'b0;
      exp_maddr = 32'h0;
      for (int i = 0; i < 16; i++) cv[i] = 1'b0;
      q.delete();
`ifdef CACHE_STATS_EN
      mh = 32'h0;
      mm = 32'h0;
`endif
    end else begin
      exp_rst = 1'b0;
      b0 = busy;
      if (b0 == 1 && bus.st_enable && bus.st_addr == m_addr) begin
        m_fwd = 1'b1;
        m_fd = bus.st_data;
      end
      if (bus.st_enable && cv[bus.st_addr % 16] && ca[bus.st_addr % 16] == bus.st_addr)
        cd[bus.st_addr % 16] = bus.st_data;
      if (b0 == 2) busy = 0;
      if (b0 == 0 && bus.c_read_enable) begin
        if (cv[bus.c_ptr % 16] && ca[bus.c_ptr % 16] == bus.c_ptr) begin
          pr.cyc = cyc; pr.d = cd[bus.c_ptr % 16]; pr.h = 1'b1;
          q.push_back(pr);
          busy = 2;
`ifdef CACHE_STATS_EN
          if (mh != 32'hFFFFFFFF) mh = mh + 1;
`endif
        end else begin
          busy = 1;
          m_addr = bus.c_ptr;
          m_fwd = 1'b0;
          exp_req = 1'b1;
          exp_maddr = bus.c_ptr;
        end
      end
      if (b0 == 1 && bus.mem_ack) begin
        fv = m_fwd ? m_fd : memval(m_addr);
        cv[m_addr % 16] = 1'b1;
        ca[m_addr % 16] = m_addr;
        cd[m_addr % 16] = fv;
        pr.cyc = cyc; pr.d = fv; pr.h = 1'b0;
        q.push_back(pr);
        busy = 2;
        exp_req = 1'b0;
`ifdef CACHE_STATS_EN
        if (mm != 32'hFFFFFFFF) mm = mm + 1;
`endif
      end
    end
  end
  // monitor: compares DUT outputs each cycle against the model and pops responses from the scoreboard
  always @(negedge clk) if (started) begin
    if (exp_rst) begin
      chk("rst_c_out", bus.c_out, 32'h0);
      chk("rst_c_hit", {31'b0, bus.c_hit}, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
    end
    chk("mem_req", {31'b0, bus.mem_req}, {31'b0, exp_req});
    if (exp_req) chk("mem_addr", bus.mem_addr, exp_maddr);
    if (q.size() != 0 && q[0].cyc == cyc) begin
      r = q.pop_front();
      chk("c_ready", {31'b0, bus.c_ready}, 32'h1);
      chk("c_out", bus.c_out, r.d);
      chk("c_hit", {31'b0, bus.c_hit}, {31'b0, r.h});
    end else
      chk("c_ready_idle", {31'b0, bus.c_ready}, 32'h0);
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, mh);
    chk("miss_count", miss_count, mm);
`endif
  end
  // memory responder: acks each request after ack_dly cycles with the backing memory word
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_req) begin
        repeat (ack_dly) @(negedge clk);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = memval(bus.mem_addr);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end
  task automatic rnd_st(input bit en, input logic [31:0] a);
    bus.st_enable = en && $urandom_range(0, 2) == 0;
    bus.st_addr = $urandom_range(0, 1) != 0 ? a : 32'($urandom_range(0, 47));
    bus.st_data = $urandom;
  endtask
  task automatic rd(input logic [31:0] a, input int dly, input bit fw, input logic [31:0] fd, input bit rs);
    ack_dly = dly;
    @(negedge clk);
    bus.c_read_enable = 1'b1;
    bus.c_ptr = a;
    rnd_st(rs, a);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (fw && k == 0) begin
        bus.st_enable = 1'b1;
        bus.st_addr = a;
        bus.st_data = fd;
      end else
        rnd_st(rs, a);
      if (bus.c_ready) break;
    end
    if (!bus.c_ready) chk("read_timeout", {31'b0, bus.c_ready}, 32'h1);
    bus.c_read_enable = 1'b0;
    @(negedge clk);
    bus.st_enable = 1'b0;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.st_enable = 1'b1;
    bus.st_addr = a;
    bus.st_data = d;
    @(negedge clk);
    bus.st_enable = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.c_read_enable = 1'b0;
    bus.c_ptr = 32'h0;
    bus.st_enable = 1'b0;
    bus.st_addr = 32'h0;
    bus.st_data = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(32'h25, 3, 0, 0, 0);
    rd(32'h25, 3, 0, 0, 0);
    rd(32'h35, 2, 0, 0, 0);
    rd(32'h25, 1, 0, 0, 0);
    st(32'h35, 32'h22222222);
    rd(32'h35, 1, 0, 0, 0);
    st(32'h45, 32'h33333333);
    rd(32'h45, 0, 0, 0, 0);
    rd(32'h07, 3, 1, 32'hCAFEF00D, 0);
    rd(32'h07, 3, 0, 0, 0);
    ack_dly = 3;
    @(negedge clk);
    bus.c_read_enable = 1'b1;
    bus.c_ptr = 32'h55;
    @(negedge clk);
    reset = 1'b1;
    bus.c_read_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    rd(32'h25, 2, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      rd(32'($urandom_range(0, 47)), $urandom_range(0, 4), 1'b0, 32'h0, 1'b1);
    repeat (5) @(negedge clk);
    chk("pending_responses", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
